id_decode_stage: RTL and testbench

Registered MIPS instruction-decode stage between IF/ID and EX. Decodes logic, shift and add/sub instructions and forwards operands from a parametrised number of later pipeline stages. Detects load-use hazards and stalls on them. Presents the decoded operation in an internal ID/EX output register with valid/ready handshakes on both sides.

---
 rtl/id_decode_stage.sv | 256 +++++++++++++++++++++++++
 tb/tb_id_decode_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_stage.sv
// MIPS instruction-decode stage: decodes logic/shift/add-sub ops, forwards operands from
// later stages, interlocks on load-use and holds the result in a handshaked ID/EX register.
module id_decode_stage #(
    parameter int N_FWD  = 2,
    parameter bit HAZ_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          pc_i,
    input  logic [31:0]          inst_i,
    input  logic                 flush_i,
    output logic [4:0]           rf_raddr1_o,
    output logic [4:0]           rf_raddr2_o,
    input  logic [31:0]          rf_rdata1_i,
    input  logic [31:0]          rf_rdata2_i,
    input  logic [N_FWD-1:0]     fwd_wreg_i,
    input  logic [5*N_FWD-1:0]   fwd_wd_i,
    input  logic [32*N_FWD-1:0]  fwd_wdata_i,
    input  logic                 ld_pend_i,
    input  logic [4:0]           ld_wd_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          pc_o,
    output logic [2:0]           alusel_o,
    output logic [7:0]           aluop_o,
    output logic [31:0]          reg1_o,
    output logic [31:0]          reg2_o,
    output logic [4:0]           wd_o,
    output logic                 wreg_o,
    output logic                 illegal_o
);

    localparam logic [2:0] SEL_NOP   = 3'd0;
    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_ARITH = 3'd3;

    localparam logic [7:0] ALU_NOP  = 8'h00;
    localparam logic [7:0] ALU_AND  = 8'h01;
    localparam logic [7:0] ALU_OR   = 8'h02;
    localparam logic [7:0] ALU_XOR  = 8'h03;
    localparam logic [7:0] ALU_NOR  = 8'h04;
    localparam logic [7:0] ALU_SLL  = 8'h08;
    localparam logic [7:0] ALU_SRL  = 8'h09;
    localparam logic [7:0] ALU_SRA  = 8'h0A;
    localparam logic [7:0] ALU_ADDU = 8'h10;
    localparam logic [7:0] ALU_SUBU = 8'h11;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign op    = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign sa    = inst_i[10:6];
    assign funct = inst_i[5:0];
    assign imm   = inst_i[15:0];

    assign rf_raddr1_o = rs;
    assign rf_raddr2_o = rt;

    logic [2:0]  dec_alusel;
    logic [7:0]  dec_aluop;
    logic [4:0]  dec_wd;
    logic        dec_wreg_raw;
    logic        dec_wreg;
    logic        dec_illegal;
    logic        re1;
    logic        re2;
    logic [31:0] imm1;
    logic [31:0] imm2;

    always_comb begin
        dec_alusel   = SEL_NOP;
        dec_aluop    = ALU_NOP;
        dec_wd       = 5'd0;
        dec_wreg_raw = 1'b0;
        dec_illegal  = 1'b0;
        re1          = 1'b0;
        re2          = 1'b0;
        imm1         = 32'd0;
        imm2         = 32'd0;
        case (op)
            OPC_SPECIAL: begin
                case (funct)
                    FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        dec_alusel   = SEL_LOGIC;
                        re1          = 1'b1;
                        re2          = 1'b1;
                        dec_wd       = rd;
                        dec_wreg_raw = 1'b1;
                        case (funct)
                            FN_AND:  dec_aluop = ALU_AND;
                            FN_OR:   dec_aluop = ALU_OR;
                            FN_XOR:  dec_aluop = ALU_XOR;
                            default: dec_aluop = ALU_NOR;
                        endcase
                    end
                    FN_ADDU, FN_SUBU: begin
                        dec_alusel   = SEL_ARITH;
                        dec_aluop    = (funct == FN_ADDU) ? ALU_ADDU : ALU_SUBU;
                        re1          = 1'b1;
                        re2          = 1'b1;
                        dec_wd       = rd;
                        dec_wreg_raw = 1'b1;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        dec_alusel   = SEL_SHIFT;
                        re2          = 1'b1;
                        imm1         = {27'd0, sa};
                        dec_wd       = rd;
                        dec_wreg_raw = 1'b1;
                        case (funct)
                            FN_SLL:  dec_aluop = ALU_SLL;
                            FN_SRL:  dec_aluop = ALU_SRL;
                            default: dec_aluop = ALU_SRA;
                        endcase
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_ANDI, OPC_ORI, OPC_XORI: begin
                dec_alusel   = SEL_LOGIC;
                re1          = 1'b1;
                imm2         = {16'd0, imm};
                dec_wd       = rt;
                dec_wreg_raw = 1'b1;
                case (op)
                    OPC_ANDI: dec_aluop = ALU_AND;
                    OPC_ORI:  dec_aluop = ALU_OR;
                    default:  dec_aluop = ALU_XOR;
                endcase
            end
            OPC_ADDIU: begin
                dec_alusel   = SEL_ARITH;
                dec_aluop    = ALU_ADDU;
                re1          = 1'b1;
                imm2         = {{16{imm[15]}}, imm};
                dec_wd       = rt;
                dec_wreg_raw = 1'b1;
            end
            OPC_LUI: begin
                // LUI is an OR against zero, so rs is never consulted
                dec_alusel   = SEL_LOGIC;
                dec_aluop    = ALU_OR;
                imm2         = {imm, 16'd0};
                dec_wd       = rt;
                dec_wreg_raw = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign dec_wreg = dec_wreg_raw && (dec_wd != 5'd0);

    logic [31:0] src1;
    logic [31:0] src2;

    // Walk from the oldest source down so the youngest match wins
    always_comb begin
        src1 = rf_rdata1_i;
        src2 = rf_rdata2_i;
        for (int k = N_FWD - 1; k >= 0; k--) begin
            if (fwd_wreg_i[k] && (fwd_wd_i[5*k +: 5] == rs))
                src1 = fwd_wdata_i[32*k +: 32];
            if (fwd_wreg_i[k] && (fwd_wd_i[5*k +: 5] == rt))
                src2 = fwd_wdata_i[32*k +: 32];
        end
        if (rs == 5'd0)
            src1 = 32'd0;
        if (rt == 5'd0)
            src2 = 32'd0;
    end

    logic [31:0] dec_reg1;
    logic [31:0] dec_reg2;

    assign dec_reg1 = re1 ? src1 : imm1;
    assign dec_reg2 = re2 ? src2 : imm2;

    logic haz;

    generate
        if (HAZ_EN) begin : g_haz
            assign haz = in_valid && ld_pend_i && (ld_wd_i != 5'd0) &&
                         ((re1 && (rs == ld_wd_i)) || (re2 && (rt == ld_wd_i)));
        end else begin : g_no_haz
            assign haz = 1'b0;
        end
    endgenerate

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !haz && !flush_i && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            pc_o      <= 32'd0;
            alusel_o  <= 3'd0;
            aluop_o   <= 8'd0;
            reg1_o    <= 32'd0;
            reg2_o    <= 32'd0;
            wd_o      <= 5'd0;
            wreg_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else if (flush_i) begin
            out_valid <= 1'b0;
            illegal_o <= 1'b0;
        end else if (adv) begin
            if (haz) begin
                out_valid <= 1'b0;
                wreg_o    <= 1'b0;
            end else if (in_valid) begin
                out_valid <= 1'b1;
                pc_o      <= pc_i;
                alusel_o  <= dec_alusel;
                aluop_o   <= dec_aluop;
                reg1_o    <= dec_reg1;
                reg2_o    <= dec_reg2;
                wd_o      <= dec_wd;
                wreg_o    <= dec_wreg;
                illegal_o <= dec_illegal;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: a table of decode/forwarding vectors plus
// hand-written hazard, backpressure, flush and reset sequences.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        flush_i;
    logic [4:0]  rf_raddr1_o;
    logic [4:0]  rf_raddr2_o;
    logic [31:0] rf_rdata1_i;
    logic [31:0] rf_rdata2_i;
    logic [1:0]  fwd_wreg_i;
    logic [9:0]  fwd_wd_i;
    logic [63:0] fwd_wdata_i;
    logic        ld_pend_i;
    logic [4:0]  ld_wd_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_o;
    logic [2:0]  alusel_o;
    logic [7:0]  aluop_o;
    logic [31:0] reg1_o;
    logic [31:0] reg2_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic        illegal_o;

    always #5 clk = ~clk;

    id_decode_stage #(.N_FWD(2), .HAZ_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst_i(inst_i), .flush_i(flush_i),
        .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
        .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
        .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
        .ld_pend_i(ld_pend_i), .ld_wd_i(ld_wd_i),
        .out_valid(out_valid), .out_ready(out_ready), .pc_o(pc_o),
        .alusel_o(alusel_o), .aluop_o(aluop_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .illegal_o(illegal_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] r_enc(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [4:0] a,
                                          input logic [5:0] fn);
        return {6'h00, s, t, d, a, fn};
    endfunction

    function automatic logic [31:0] i_enc(input logic [5:0] o, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {o, s, t, im};
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [1:0]  fw_en;
        logic [9:0]  fw_wd;
        logic [63:0] fw_data;
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic        ill;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [1:0] fw_en,
                                input logic [9:0] fw_wd, input logic [63:0] fw_data,
                                input logic [2:0] sel, input logic [7:0] op,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [4:0] wd, input logic wreg, input logic ill);
        vec_t v;
        v.inst = inst; v.rd1 = rd1; v.rd2 = rd2;
        v.fw_en = fw_en; v.fw_wd = fw_wd; v.fw_data = fw_data;
        v.sel = sel; v.op = op; v.r1 = r1; v.r2 = r2;
        v.wd = wd; v.wreg = wreg; v.ill = ill;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        fwd_wreg_i  = 2'b00;
        fwd_wd_i    = 10'd0;
        fwd_wdata_i = 64'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] cur_pc;

        // ORI $3,$0,0x1234 / XOR $5,$3,$3 with $3 forwarded from source 0
        vecs[0]  = mk(i_enc(6'h0D, 5'd0, 5'd3, 16'h1234), 32'hDEAD0001, 32'hDEAD0002, 2'b00, 10'd0, 64'd0,
                      3'd1, 8'h02, 32'h0, 32'h1234, 5'd3, 1'b1, 1'b0);
        vecs[1]  = mk(r_enc(5'd3, 5'd3, 5'd5, 5'd0, 6'h26), 32'hDEAD0001, 32'hDEAD0002,
                      2'b01, {5'd0, 5'd3}, {32'h0, 32'h1234},
                      3'd1, 8'h03, 32'h1234, 32'h1234, 5'd5, 1'b1, 1'b0);
        // Both sources write $4: the youngest (index 0) wins
        vecs[2]  = mk(r_enc(5'd4, 5'd4, 5'd6, 5'd0, 6'h24), 32'hDEAD0001, 32'hDEAD0002,
                      2'b11, {5'd4, 5'd4}, {32'h5555, 32'hAAAA},
                      3'd1, 8'h01, 32'hAAAA, 32'hAAAA, 5'd6, 1'b1, 1'b0);
        // A source writing $0 never forwards; $2 comes from source 1
        vecs[3]  = mk(r_enc(5'd0, 5'd2, 5'd10, 5'd0, 6'h25), 32'hDEAD0001, 32'h99,
                      2'b11, {5'd2, 5'd0}, {32'h77, 32'hFFFF},
                      3'd1, 8'h02, 32'h0, 32'h77, 5'd10, 1'b1, 1'b0);
        // Source 0 matches $7 but is disabled; source 1 supplies it
        vecs[4]  = mk(r_enc(5'd7, 5'd2, 5'd8, 5'd0, 6'h21), 32'h100, 32'h200,
                      2'b10, {5'd7, 5'd7}, {32'h5, 32'h1},
                      3'd3, 8'h10, 32'h5, 32'h200, 5'd8, 1'b1, 1'b0);
        vecs[5]  = mk(r_enc(5'd1, 5'd2, 5'd9, 5'd0, 6'h23), 32'h11, 32'h22, 2'b00, 10'd0, 64'd0,
                      3'd3, 8'h11, 32'h11, 32'h22, 5'd9, 1'b1, 1'b0);
        vecs[6]  = mk(r_enc(5'd1, 5'd2, 5'd11, 5'd0, 6'h27), 32'hF0F0F0F0, 32'h0F0F0000, 2'b00, 10'd0, 64'd0,
                      3'd1, 8'h04, 32'hF0F0F0F0, 32'h0F0F0000, 5'd11, 1'b1, 1'b0);
        // LUI ignores rs even when it is readable and forwardable
        vecs[7]  = mk(i_enc(6'h0F, 5'd5, 5'd9, 16'hBEEF), 32'h1234, 32'hDEAD0002,
                      2'b01, {5'd0, 5'd5}, {32'h0, 32'h999},
                      3'd1, 8'h02, 32'h0, 32'hBEEF0000, 5'd9, 1'b1, 1'b0);
        vecs[8]  = mk(r_enc(5'd0, 5'd2, 5'd1, 5'd31, 6'h03), 32'h55, 32'h80000000, 2'b00, 10'd0, 64'd0,
                      3'd2, 8'h0A, 32'd31, 32'h80000000, 5'd1, 1'b1, 1'b0);
        vecs[9]  = mk(r_enc(5'd7, 5'd5, 5'd4, 5'd3, 6'h00), 32'hABC, 32'h11, 2'b00, 10'd0, 64'd0,
                      3'd2, 8'h08, 32'd3, 32'h11, 5'd4, 1'b1, 1'b0);
        vecs[10] = mk(r_enc(5'd0, 5'd5, 5'd4, 5'd0, 6'h02), 32'h1, 32'h2,
                      2'b10, {5'd5, 5'd0}, {32'h12345678, 32'h0},
                      3'd2, 8'h09, 32'd0, 32'h12345678, 5'd4, 1'b1, 1'b0);
        vecs[11] = mk(i_enc(6'h09, 5'd3, 5'd12, 16'hFFFE), 32'h10, 32'hDEAD0002, 2'b00, 10'd0, 64'd0,
                      3'd3, 8'h10, 32'h10, 32'hFFFFFFFE, 5'd12, 1'b1, 1'b0);
        vecs[12] = mk(i_enc(6'h0C, 5'd1, 5'd13, 16'h8001), 32'hFFFF0000, 32'hDEAD0002, 2'b00, 10'd0, 64'd0,
                      3'd1, 8'h01, 32'hFFFF0000, 32'h00008001, 5'd13, 1'b1, 1'b0);
        vecs[13] = mk(i_enc(6'h0E, 5'd1, 5'd14, 16'hF0F0), 32'h1, 32'hDEAD0002, 2'b00, 10'd0, 64'd0,
                      3'd1, 8'h03, 32'h1, 32'h0000F0F0, 5'd14, 1'b1, 1'b0);
        vecs[14] = mk(i_enc(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h1, 32'h2, 2'b00, 10'd0, 64'd0,
                      3'd0, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        vecs[15] = mk(32'h0, 32'h1, 32'h2, 2'b00, 10'd0, 64'd0,
                      3'd2, 8'h08, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        vecs[16] = mk(i_enc(6'h0D, 5'd1, 5'd0, 16'h0005), 32'h7, 32'h2, 2'b00, 10'd0, 64'd0,
                      3'd1, 8'h02, 32'h7, 32'h5, 5'd0, 1'b0, 1'b0);
        vecs[17] = mk(r_enc(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 32'h1, 32'h2, 2'b00, 10'd0, 64'd0,
                      3'd0, 8'h00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);

        rst = 1'b1; in_valid = 1'b0; pc_i = 32'd0; inst_i = 32'd0; flush_i = 1'b0;
        rf_rdata1_i = 32'd0; rf_rdata2_i = 32'd0; clear_fwd();
        ld_pend_i = 1'b0; ld_wd_i = 5'd0; out_ready = 1'b1;
        tick();
        tick();
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset pc", pc_o, 32'd0);
        chk("reset reg1", reg1_o, 32'd0);
        chk("reset wreg", {31'd0, wreg_o}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            cur_pc      = 32'h1000 + 32'(i) * 4;
            in_valid    = 1'b1;
            pc_i        = cur_pc;
            inst_i      = vecs[i].inst;
            rf_rdata1_i = vecs[i].rd1;
            rf_rdata2_i = vecs[i].rd2;
            fwd_wreg_i  = vecs[i].fw_en;
            fwd_wd_i    = vecs[i].fw_wd;
            fwd_wdata_i = vecs[i].fw_data;
            #1;
            chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            chk($sformatf("v%0d raddr1", i), {27'd0, rf_raddr1_o}, {27'd0, vecs[i].inst[25:21]});
            chk($sformatf("v%0d raddr2", i), {27'd0, rf_raddr2_o}, {27'd0, vecs[i].inst[20:16]});
            tick();
            chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d pc", i), pc_o, cur_pc);
            chk($sformatf("v%0d alusel", i), {29'd0, alusel_o}, {29'd0, vecs[i].sel});
            chk($sformatf("v%0d aluop", i), {24'd0, aluop_o}, {24'd0, vecs[i].op});
            chk($sformatf("v%0d reg1", i), reg1_o, vecs[i].r1);
            chk($sformatf("v%0d reg2", i), reg2_o, vecs[i].r2);
            if (!vecs[i].ill)
                chk($sformatf("v%0d wd", i), {27'd0, wd_o}, {27'd0, vecs[i].wd});
            chk($sformatf("v%0d wreg", i), {31'd0, wreg_o}, {31'd0, vecs[i].wreg});
            chk($sformatf("v%0d illegal", i), {31'd0, illegal_o}, {31'd0, vecs[i].ill});
        end
        clear_fwd();

        // Load-use on rs: one bubble, then accepted once the load leaves EX
        inst_i = r_enc(5'd7, 5'd2, 5'd8, 5'd0, 6'h21); pc_i = 32'h2000;
        rf_rdata1_i = 32'h30; rf_rdata2_i = 32'h40;
        ld_pend_i = 1'b1; ld_wd_i = 5'd7;
        #1;
        chk("haz rs in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("haz bubble out_valid", {31'd0, out_valid}, 32'd0);
        chk("haz bubble wreg", {31'd0, wreg_o}, 32'd0);
        ld_pend_i = 1'b0;
        #1;
        chk("haz clear in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("haz accept out_valid", {31'd0, out_valid}, 32'd1);
        chk("haz accept wreg", {31'd0, wreg_o}, 32'd1);
        chk("haz accept wd", {27'd0, wd_o}, 32'd8);
        chk("haz accept reg1", reg1_o, 32'h30);
        chk("haz accept pc", pc_o, 32'h2000);

        // Load-use through rt
        inst_i = r_enc(5'd1, 5'd7, 5'd9, 5'd0, 6'h23); pc_i = 32'h2004;
        ld_pend_i = 1'b1; ld_wd_i = 5'd7;
        #1;
        chk("haz rt in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("haz rt out_valid", {31'd0, out_valid}, 32'd0);

        // Pending load to $0 never stalls
        inst_i = i_enc(6'h0D, 5'd0, 5'd3, 16'h0001); ld_wd_i = 5'd0;
        #1;
        chk("ld $0 in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("ld $0 out_valid", {31'd0, out_valid}, 32'd1);

        // LUI does not read rs, so a load to its rs field is harmless
        inst_i = i_enc(6'h0F, 5'd7, 5'd9, 16'h0001); ld_wd_i = 5'd7;
        #1;
        chk("lui no haz in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("lui no haz out_valid", {31'd0, out_valid}, 32'd1);
        ld_pend_i = 1'b0; ld_wd_i = 5'd0;

        // Backpressure freezes an illegal op, then flush clears it
        inst_i = i_enc(6'h3F, 5'd0, 5'd0, 16'h0); pc_i = 32'h500;
        tick();
        chk("bp load illegal", {31'd0, illegal_o}, 32'd1);
        out_ready = 1'b0;
        inst_i = i_enc(6'h0D, 5'd1, 5'd2, 16'h00FF); pc_i = 32'h600;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d in_ready", c), {31'd0, in_ready}, 32'd0);
            tick();
            chk($sformatf("bp%0d out_valid", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d pc", c), pc_o, 32'h500);
            chk($sformatf("bp%0d illegal", c), {31'd0, illegal_o}, 32'd1);
        end
        flush_i = 1'b1;
        #1;
        chk("flush in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush illegal", {31'd0, illegal_o}, 32'd0);
        flush_i = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("idle out_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream
        out_ready = 1'b1; in_valid = 1'b1;
        inst_i = i_enc(6'h0D, 5'd1, 5'd3, 16'h1234); pc_i = 32'h700; rf_rdata1_i = 32'h55;
        tick();
        chk("pre-rst out_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst pc", pc_o, 32'd0);
        chk("rst alusel", {29'd0, alusel_o}, 32'd0);
        chk("rst aluop", {24'd0, aluop_o}, 32'd0);
        chk("rst reg1", reg1_o, 32'd0);
        chk("rst reg2", reg2_o, 32'd0);
        chk("rst wd", {27'd0, wd_o}, 32'd0);
        chk("rst wreg", {31'd0, wreg_o}, 32'd0);
        chk("rst illegal", {31'd0, illegal_o}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
